// File: rtl/dac_pkg.sv
// dac_pkg: shared state encoding and default geometry for the DAC frame controller.
package dac_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  localparam int DAC_DATA_W  = 12;
  localparam int DAC_FRAME_W = 16;
  localparam int DAC_GAP_DEF = 2;
endpackage

// File: rtl/dac_frame_ctrl.sv
// dac_frame_ctrl: sample handshake, load/shift control and frame sync for the DAC shift register.
// Optional DAC_FRAME_SKID_EN adds a one-entry skid buffer so frames run back-to-back without IDLE.
module dac_frame_ctrl
  import dac_pkg::*;
#(
  parameter int DATA_W     = DAC_DATA_W,
  parameter int FRAME_W    = DAC_FRAME_W,
  parameter int GAP_CYCLES = DAC_GAP_DEF
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [DATA_W-1:0] dac_data,
  output logic              desp_enable,
  output logic              sync_n,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = $clog2(FRAME_W);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state, state_n;
  logic [CW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic accept, bit_last, gap_last, gap_end, reload, ready_n;
  assign accept   = sample_valid & sample_ready;
  assign bit_last = bit_cnt == CW'(FRAME_W - 1);
  assign gap_last = gap_cnt == GW'(GAP_CYCLES - 1);
  assign gap_end  = state == GAP && gap_last;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? LOAD : IDLE;
      LOAD:    state_n = SHIFT;
      SHIFT:   state_n = bit_last ? GAP : SHIFT;
      GAP:     state_n = gap_last ? (reload ? LOAD : IDLE) : GAP;
      default: state_n = IDLE;
    endcase
  end
`ifdef DAC_FRAME_SKID_EN
  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  assign reload  = gap_end && (skid_full || accept);
  assign ready_n = gap_end || !(skid_full || (accept && state != IDLE));
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_data <= '0;
      dac_data  <= '0;
    end else begin
      if (accept && state != IDLE && !gap_end) begin
        skid_full <= 1'b1;
        skid_data <= sample_in;
      end else if (gap_end) begin
        skid_full <= 1'b0;
      end
      // A buffered sample wins at frame end; otherwise only a direct acceptance updates dac_data.
      if (gap_end && skid_full) dac_data <= skid_data;
      else if (accept && (state == IDLE || gap_end)) dac_data <= sample_in;
    end
  end
`else
  assign reload  = 1'b0;
  assign ready_n = state_n == IDLE;
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) dac_data <= '0;
    else if (accept) dac_data <= sample_in;
  end
`endif
  // Outputs are registered decodes of the current state, lagging it by one cycle.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      sample_ready <= 1'b0;
      desp_enable  <= 1'b0;
      sync_n       <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= state == SHIFT ? (bit_last ? bit_cnt : bit_cnt + 1'b1) : '0;
      gap_cnt      <= state == GAP ? (gap_last ? gap_cnt : gap_cnt + 1'b1) : '0;
      sample_ready <= ready_n;
      desp_enable  <= state == SHIFT;
      sync_n       <= state != SHIFT;
      busy         <= state != IDLE;
      frame_done   <= state == GAP && gap_cnt == '0;
    end
  end
endmodule

// File: tb/tb_dac_frame_ctrl.sv
// tb_dac_frame_ctrl: directed bench for dac_frame_ctrl driving a model of the downstream shift register.
module tb_dac_frame_ctrl;
  logic        sclk = 1'b0, rst_n = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, desp_enable, sync_n, busy, frame_done;
  logic [11:0] dac_data;
  always #5 sclk = ~sclk;

  dac_frame_ctrl dut (
    .sclk(sclk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .dac_data(dac_data), .desp_enable(desp_enable),
    .sync_n(sync_n), .busy(busy), .frame_done(frame_done)
  );

  logic [15:0] sr;
  always @(posedge sclk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= desp_enable ? {sr[14:0], 1'b0} : {4'b0000, dac_data};

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  logic [15:0] word = '0;
  int nlow = 0, done_cnt = 0;
  int fall_q[$], len_q[$], acc_q[$];
  logic [15:0] word_q[$];
  always @(negedge sclk) begin
    if (!rst_n) begin
      nlow = 0;
      word = '0;
    end else begin
      if (!sync_n) begin
        if (nlow == 0) fall_q.push_back(cyc);
        word = {word[14:0], sr[15]};
        nlow++;
      end else if (nlow != 0) begin
        word_q.push_back(word);
        len_q.push_back(nlow);
        nlow = 0;
        word = '0;
      end
      if (frame_done) done_cnt++;
    end
  end

  int checks = 0, failures = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    acc = sample_valid && sample_ready;
    @(posedge sclk);
    #1;
    if (acc) acc_q.push_back(cyc);
  endtask

  task automatic clr();
    fall_q.delete(); len_q.delete(); acc_q.delete(); word_q.delete();
  endtask

  task automatic wait_acc(string n, int cnt);
    int k = 0;
    while (acc_q.size() < cnt && k < 60) begin tick(); k++; end
    chk({n, "_acc_timeout"}, 32'(acc_q.size() >= cnt), 32'd1);
  endtask

  task automatic send(string n, logic [11:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    wait_acc(n, acc_q.size() + 1);
    sample_valid = 1'b0;
  endtask

  task automatic chk_frame(string n, int i, logic [15:0] w);
    chk({n, "_word"}, word_q.size() > i ? 32'(word_q[i]) : 32'hdeadbeef, 32'(w));
    chk({n, "_len"}, len_q.size() > i ? 32'(len_q[i]) : 32'hdeadbeef, 32'd16);
  endtask

  typedef struct {
    logic [11:0] s;
    logic [15:0] w;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int d;
    tbl[0] = '{12'hA5C, 16'h0A5C};
    tbl[1] = '{12'h001, 16'h0001};
    tbl[2] = '{12'hFFF, 16'h0FFF};
    tbl[3] = '{12'h800, 16'h0800};
    tbl[4] = '{12'h000, 16'h0000};
    tbl[5] = '{12'h5A3, 16'h05A3};

    sample_in = 12'hABC;
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sync_n", 32'(sync_n), 32'd1);
      chk("rst_desp", 32'(desp_enable), 32'd0);
      chk("rst_dac", 32'(dac_data), 32'd0);
      chk("rst_ready", 32'(sample_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    sample_valid = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(sample_ready), 32'd1);
    chk("dac_after_rst", 32'(dac_data), 32'd0);
    clr();

    for (int i = 0; i < 6; i++) begin
      clr();
      d = done_cnt;
      send("vec", tbl[i].s);
      chk("vec_dac", 32'(dac_data), 32'(tbl[i].s));
      chk("vec_busy_run", 32'(busy), 32'd0);
      repeat (25) tick();
      chk("vec_dac_hold", 32'(dac_data), 32'(tbl[i].s));
      chk_frame("vec", 0, tbl[i].w);
      chk("vec_frames", 32'(word_q.size()), 32'd1);
      chk("vec_fall", fall_q.size() > 0 ? 32'(fall_q[0] - acc_q[0]) : 32'hdeadbeef, 32'd2);
      chk("vec_done", 32'(done_cnt - d), 32'd1);
      chk("vec_idle_busy", 32'(busy), 32'd0);
      chk("vec_idle_sync", 32'(sync_n), 32'd1);
    end

    clr();
    sample_in = 12'h001;
    sample_valid = 1'b1;
    wait_acc("b2b1", 1);
    sample_in = 12'hFFF;
    wait_acc("b2b2", 2);
    sample_valid = 1'b0;
    repeat (45) tick();
    chk_frame("b2b_f0", 0, 16'h0001);
    chk_frame("b2b_f1", 1, 16'h0FFF);
`ifdef DAC_FRAME_SKID_EN
    chk("b2b_period", fall_q.size() > 1 ? 32'(fall_q[1] - fall_q[0]) : 32'hdeadbeef, 32'd19);
`else
    chk("b2b_acc_gap", acc_q.size() > 1 ? 32'(acc_q[1] - acc_q[0]) : 32'hdeadbeef, 32'd20);
    chk("b2b_period", fall_q.size() > 1 ? 32'(fall_q[1] - fall_q[0]) : 32'hdeadbeef, 32'd20);

    clr();
    send("bp", 12'h2B7);
    repeat (5) tick();
    sample_in = 12'h6E1;
    sample_valid = 1'b1;
    chk("bp_ready_low", 32'(sample_ready), 32'd0);
    repeat (10) tick();
    chk("bp_not_taken", 32'(acc_q.size()), 32'd1);
    chk("bp_dac_hold", 32'(dac_data), 32'h2B7);
    wait_acc("bp", 2);
    sample_valid = 1'b0;
    chk("bp_acc_gap", acc_q.size() > 1 ? 32'(acc_q[1] - acc_q[0]) : 32'hdeadbeef, 32'd20);
    chk("bp_dac_new", 32'(dac_data), 32'h6E1);
    repeat (25) tick();
    chk_frame("bp_f0", 0, 16'h02B7);
    chk_frame("bp_f1", 1, 16'h06E1);
`endif

`ifdef DAC_FRAME_SKID_EN
    clr();
    d = done_cnt;
    send("skid", 12'h123);
    repeat (4) tick();
    sample_in = 12'h456;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("skid_taken", 32'(acc_q.size()), 32'd2);
    chk("skid_ready_low", 32'(sample_ready), 32'd0);
    repeat (12) tick();
    chk("skid_ready_still_low", 32'(sample_ready), 32'd0);
    chk("skid_dac_hold", 32'(dac_data), 32'h123);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("skid_no_idle", 32'(busy), 32'd1);
    end
    chk("skid_ready_back", 32'(sample_ready), 32'd1);
    chk("skid_dac_next", 32'(dac_data), 32'h456);
    repeat (25) tick();
    chk_frame("skid_f0", 0, 16'h0123);
    chk_frame("skid_f1", 1, 16'h0456);
    chk("skid_period", fall_q.size() > 1 ? 32'(fall_q[1] - fall_q[0]) : 32'hdeadbeef, 32'd19);
    chk("skid_done", 32'(done_cnt - d), 32'd2);
`endif

    clr();
    send("mid", 12'h3C3);
    repeat (10) tick();
    chk("mid_in_shift", 32'(sync_n), 32'd0);
    chk("mid_bit7", 32'(sr[15]), 32'(1'b1));
    d = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_sync_n", 32'(sync_n), 32'd1);
    chk("mid_desp", 32'(desp_enable), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(sample_ready), 32'd0);
    chk("mid_dac", 32'(dac_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mid_no_done", 32'(done_cnt - d), 32'd0);
    clr();
    send("post", 12'h800);
    repeat (25) tick();
    chk_frame("post", 0, 16'h0800);
    chk("post_done", 32'(done_cnt - d), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
